// File: rtl/hpi_pio_ctrl.sv
// hpi_pio_ctrl: Avalon-MM GPIO slave for the CY7C67200 HPI pins, with per-bit direction,
// input synchroniser, edge capture (W1C), masked irq. Optional OUTSET/OUTCLR: HPI_PIO_OUTSET_CLR_EN.
module hpi_pio_ctrl #(
    parameter int                DATA_W      = 16,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0,
    parameter logic [DATA_W-1:0] DIR_RESET   = '0,
    parameter int                EDGE_TYPE   = 0,
    parameter int                SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [DATA_W-1:0] in_port,
    output logic [DATA_W-1:0] out_port,
    output logic [DATA_W-1:0] out_en,
    output logic              irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
`ifdef HPI_PIO_OUTSET_CLR_EN
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
`endif

    logic [DATA_W-1:0]                  r_data_out;
    logic [DATA_W-1:0]                  r_dir;
    logic [DATA_W-1:0]                  r_irq_mask;
    logic [DATA_W-1:0]                  r_edge_cap;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] r_sync;
    logic [DATA_W-1:0]                  r_in_prev;
    logic [31:0]                        r_readdata;
    logic                               r_irq;

    logic              w_wr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_in_sync;
    logic [DATA_W-1:0] w_edge;
    logic [DATA_W-1:0] w_cap_clr;
    logic [31:0]       w_rd_mux;
    logic              w_unused;

    assign w_wr      = chipselect & ~write_n;
    assign w_wdata   = writedata[DATA_W-1:0];
    assign w_unused  = ^writedata;
    assign w_in_sync = r_sync[SYNC_STAGES-1];

    assign readdata  = r_readdata;
    assign out_port  = r_data_out;
    assign out_en    = r_dir;
    assign irq       = r_irq;

    // Sync chain and edge history reset to 0, so a pad high at reset exit reads as one rising edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync    <= '0;
            r_in_prev <= '0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], in_port};
            r_in_prev <= w_in_sync;
        end
    end

    generate
        if (EDGE_TYPE == 1) begin : g_fall
            assign w_edge = ~w_in_sync & r_in_prev;
        end else if (EDGE_TYPE == 2) begin : g_any
            assign w_edge = w_in_sync ^ r_in_prev;
        end else begin : g_rise
            assign w_edge = w_in_sync & ~r_in_prev;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out <= RESET_VALUE;
            r_dir      <= DIR_RESET;
            r_irq_mask <= '0;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:    r_data_out <= w_wdata;
                ADDR_DIR:     r_dir      <= w_wdata;
                ADDR_IRQMASK: r_irq_mask <= w_wdata;
`ifdef HPI_PIO_OUTSET_CLR_EN
                ADDR_OUTSET:  r_data_out <= r_data_out | w_wdata;
                ADDR_OUTCLR:  r_data_out <= r_data_out & ~w_wdata;
`endif
                default: ;
            endcase
        end
    end

    assign w_cap_clr = (w_wr && address == ADDR_EDGECAP) ? w_wdata : '0;

    // A new edge in the same cycle as its clear keeps the bit set so no event is lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_edge_cap <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_edge_cap <= (r_edge_cap & ~w_cap_clr) | w_edge;
            r_irq      <= |(r_edge_cap & r_irq_mask);
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            ADDR_DATA:    w_rd_mux[DATA_W-1:0] = (r_data_out & r_dir) | (w_in_sync & ~r_dir);
            ADDR_DIR:     w_rd_mux[DATA_W-1:0] = r_dir;
            ADDR_IRQMASK: w_rd_mux[DATA_W-1:0] = r_irq_mask;
            ADDR_EDGECAP: w_rd_mux[DATA_W-1:0] = r_edge_cap;
            default:      w_rd_mux = '0;
        endcase
    end

    // Read data is registered every cycle regardless of chipselect: fixed one-cycle latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_readdata <= '0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

endmodule

// File: tb/tb_hpi_pio_ctrl.sv
// Bench for hpi_pio_ctrl: directed scenario tasks plus randomized traffic checked against
// a queue-based behavioural model of the register map, synchroniser delay and edge capture.
module tb_hpi_pio_ctrl;

    localparam int SYNC_STAGES = 2;

    logic        clk;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] in_port;
    logic [15:0] out_port;
    logic [15:0] out_en;
    logic        irq;

    int checks = 0;
    int errors = 0;

    hpi_pio_ctrl #(
        .DATA_W      (16),
        .RESET_VALUE (16'hA5A5),
        .DIR_RESET   (16'h0000),
        .EDGE_TYPE   (0),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .out_en     (out_en),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: pad samples pass through a queue whose depth is the synchroniser delay.
    logic [15:0] m_data, m_dir, m_mask, m_cap;
    logic [31:0] m_rd;
    logic        m_irq;
    logic [15:0] pad_q[$];

    task automatic model_reset;
        m_data = 16'hA5A5;
        m_dir  = 16'h0000;
        m_mask = 16'h0000;
        m_cap  = 16'h0000;
        m_rd   = 32'h0;
        m_irq  = 1'b0;
        pad_q.delete();
        repeat (SYNC_STAGES + 1) pad_q.push_back(16'h0000);
    endtask

    task automatic model_step;
        logic [15:0] sync, prev, rises, wd, clr;
        logic        wr;
        if (reset) begin
            model_reset();
            return;
        end
        sync  = pad_q[SYNC_STAGES-1];
        prev  = pad_q[SYNC_STAGES];
        rises = sync & ~prev;
        wr    = chipselect && !write_n;
        wd    = writedata[15:0];
        case (address)
            3'd0:    m_rd = {16'h0, (m_data & m_dir) | (sync & ~m_dir)};
            3'd1:    m_rd = {16'h0, m_dir};
            3'd2:    m_rd = {16'h0, m_mask};
            3'd3:    m_rd = {16'h0, m_cap};
            default: m_rd = 32'h0;
        endcase
        m_irq = (m_cap & m_mask) != 16'h0;
        clr = (wr && address == 3'd3) ? wd : 16'h0;
        m_cap = (m_cap & ~clr) | rises;
        if (wr) begin
            if (address == 3'd0) m_data = wd;
            if (address == 3'd1) m_dir  = wd;
            if (address == 3'd2) m_mask = wd;
`ifdef HPI_PIO_OUTSET_CLR_EN
            if (address == 3'd4) m_data = m_data | wd;
            if (address == 3'd5) m_data = m_data & ~wd;
`endif
        end
        pad_q.push_front(in_port);
        void'(pad_q.pop_back());
    endtask

    task automatic cycle;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic bus_idle;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        cycle();
        bus_idle();
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] v);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        cycle();
        v = readdata;
        bus_idle();
    endtask

    task automatic test_reset;
        logic [31:0] v;
        repeat (2) cycle();
        checks++; if (out_port !== 16'hA5A5) begin errors++; $display("FAIL reset_out_port: got %h expected %h", out_port, 16'hA5A5); end
        checks++; if (out_en !== 16'h0000) begin errors++; $display("FAIL reset_out_en: got %h expected %h", out_en, 16'h0000); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
        checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL reset_readdata: got %h expected 0", readdata); end
        reset = 1'b0;
        for (int a = 0; a < 4; a++) begin
            bus_read(3'(a), v);
            checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_read_addr%0d: got %h expected 0", a, v); end
        end
    endtask

    task automatic test_dir_mux;
        logic [31:0] v;
        bus_write(3'd1, 32'h0000_00FF);
        checks++; if (out_en !== 16'h00FF) begin errors++; $display("FAIL dir_out_en: got %h expected %h", out_en, 16'h00FF); end
        bus_write(3'd0, 32'h0000_1234);
        checks++; if (out_port !== 16'h1234) begin errors++; $display("FAIL dir_out_port: got %h expected %h", out_port, 16'h1234); end
        in_port = 16'hABCD;
        repeat (3) cycle();
        bus_read(3'd0, v);
        checks++; if (v !== 32'h0000_AB34) begin errors++; $display("FAIL dir_read_mux: got %h expected %h", v, 32'h0000_AB34); end
    endtask

    task automatic test_rising_edge;
        logic [31:0] v;
        in_port = 16'h0000;
        repeat (4) cycle();
        bus_write(3'd3, 32'h0000_FFFF);
        bus_read(3'd3, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL edge_cleared: got %h expected 0", v); end
        // Hold address 3 idle so readdata tracks edge_cap one cycle late.
        address = 3'd3;
        in_port = 16'h0008;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++; if (readdata !== 32'h0) begin errors++; $display("FAIL edge_early_%0d: got %h expected 0", i, readdata); end
        end
        cycle();
        checks++; if (readdata !== 32'h0000_0008) begin errors++; $display("FAIL edge_rise_bit3: got %h expected %h", readdata, 32'h8); end
        in_port = 16'h0000;
        repeat (5) cycle();
        bus_read(3'd3, v);
        checks++; if (v !== 32'h0000_0008) begin errors++; $display("FAIL edge_fall_ignored: got %h expected %h", v, 32'h8); end
        in_port = 16'h0001;
        repeat (4) cycle();
        bus_read(3'd3, v);
        checks++; if (v !== 32'h0000_0009) begin errors++; $display("FAIL edge_cap_0009: got %h expected %h", v, 32'h9); end
    endtask

    task automatic test_irq_w1c;
        logic [31:0] v;
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_unmasked: got %b expected 0", irq); end
        bus_write(3'd2, 32'h0000_0008);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_mask_same_cycle: got %b expected 0", irq); end
        cycle();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_assert: got %b expected 1", irq); end
        bus_write(3'd3, 32'h0000_0008);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold_on_clear: got %b expected 1", irq); end
        cycle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_deassert_w1c: got %b expected 0", irq); end
        bus_read(3'd3, v);
        checks++; if (v !== 32'h0000_0001) begin errors++; $display("FAIL w1c_partial: got %h expected %h", v, 32'h1); end
        bus_write(3'd2, 32'h0000_0001);
        cycle();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_mask_bit0: got %b expected 1", irq); end
        bus_write(3'd2, 32'h0000_0000);
        cycle();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_deassert_mask: got %b expected 0", irq); end
    endtask

    task automatic test_collision;
        logic [31:0] v;
        in_port = 16'h0000;
        repeat (4) cycle();
        in_port = 16'h0001;
        cycle();
        cycle();
        bus_write(3'd3, 32'h0000_0001);
        bus_read(3'd3, v);
        checks++; if (v !== 32'h0000_0001) begin errors++; $display("FAIL collision_set_wins: got %h expected %h", v, 32'h1); end
        bus_write(3'd3, 32'h0000_0001);
        bus_read(3'd3, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL w1c_no_edge: got %h expected 0", v); end
    endtask

    task automatic test_outset_clr;
        logic [31:0] v;
        logic [15:0] exp_set, exp_clr;
`ifdef HPI_PIO_OUTSET_CLR_EN
        exp_set = 16'h00F3;
        exp_clr = 16'h00E3;
`else
        exp_set = 16'h00F0;
        exp_clr = 16'h00F0;
`endif
        bus_write(3'd0, 32'h0000_00F0);
        bus_write(3'd4, 32'h0000_0003);
        checks++; if (out_port !== exp_set) begin errors++; $display("FAIL outset: got %h expected %h", out_port, exp_set); end
        bus_write(3'd5, 32'h0000_0010);
        checks++; if (out_port !== exp_clr) begin errors++; $display("FAIL outclr: got %h expected %h", out_port, exp_clr); end
        for (int a = 4; a < 8; a++) begin
            bus_read(3'(a), v);
            checks++; if (v !== 32'h0) begin errors++; $display("FAIL read_addr%0d_zero: got %h expected 0", a, v); end
        end
    endtask

    task automatic test_upper_bits;
        logic [31:0] v;
        bus_write(3'd0, 32'hFFFF_0F0F);
        checks++; if (out_port !== 16'h0F0F) begin errors++; $display("FAIL upper_data: got %h expected %h", out_port, 16'h0F0F); end
        bus_write(3'd1, 32'hABCD_FFFF);
        bus_read(3'd1, v);
        checks++; if (v !== 32'h0000_FFFF) begin errors++; $display("FAIL upper_dir_read: got %h expected %h", v, 32'hFFFF); end
        bus_read(3'd0, v);
        checks++; if (v !== 32'h0000_0F0F) begin errors++; $display("FAIL all_out_read: got %h expected %h", v, 32'h0F0F); end
    endtask

    task automatic test_reset_mid_write;
        address    = 3'd0;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = 32'h0000_5555;
        #2 reset = 1'b1;
        #1;
        checks++; if (out_port !== 16'hA5A5) begin errors++; $display("FAIL async_reset_out: got %h expected %h", out_port, 16'hA5A5); end
        checks++; if (out_en !== 16'h0000) begin errors++; $display("FAIL async_reset_en: got %h expected 0", out_en); end
        cycle();
        bus_idle();
        reset = 1'b0;
        cycle();
        checks++; if (out_port !== 16'hA5A5) begin errors++; $display("FAIL abort_write: got %h expected %h", out_port, 16'hA5A5); end
    endtask

    task automatic test_reset_exit_edge;
        logic [31:0] v;
        in_port = 16'h0010;
        reset = 1'b1;
        repeat (2) cycle();
        reset = 1'b0;
        repeat (4) cycle();
        bus_read(3'd3, v);
        checks++; if (v !== 32'h0000_0010) begin errors++; $display("FAIL reset_exit_edge: got %h expected %h", v, 32'h10); end
        bus_write(3'd3, 32'h0000_FFFF);
        repeat (3) cycle();
        bus_read(3'd3, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_exit_single: got %h expected 0", v); end
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            address    = 3'($urandom_range(0, 7));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = 1'($urandom_range(0, 1));
            writedata  = $urandom;
            if ($urandom_range(0, 3) == 0) in_port = in_port ^ 16'($urandom);
            cycle();
            checks++; if (readdata !== m_rd) begin errors++; $display("FAIL rand_readdata[%0d]: got %h expected %h", i, readdata, m_rd); end
            checks++; if (out_port !== m_data) begin errors++; $display("FAIL rand_out_port[%0d]: got %h expected %h", i, out_port, m_data); end
            checks++; if (out_en !== m_dir) begin errors++; $display("FAIL rand_out_en[%0d]: got %h expected %h", i, out_en, m_dir); end
            checks++; if (irq !== m_irq) begin errors++; $display("FAIL rand_irq[%0d]: got %b expected %b", i, irq, m_irq); end
        end
        bus_idle();
    endtask

    initial begin
        reset   = 1'b1;
        address = 3'd0;
        in_port = 16'h0000;
        bus_idle();
        model_reset();
        test_reset();
        test_dir_mux();
        test_rising_edge();
        test_irq_w1c();
        test_collision();
        test_outset_clr();
        test_upper_bits();
        test_reset_mid_write();
        test_reset_exit_edge();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hpi_pio_ctrl.md
Name: hpi_pio_ctrl

Overview:
Parametrised Avalon-MM general-purpose I/O slave. It is the successor to the fixed 16-bit HPI data port. It adds:
- configurable width
- per-bit direction control
- input synchronisation
- edge capture with write-1-to-clear
- masked interrupt output

It sits between the Nios II Avalon fabric and the CY7C67200 HPI data, control and status pins. Top level drives the pad tristates from out_port/out_en.

Parameters:
DATA_W, 16, port width in bits; legal 1..32
RESET_VALUE, 0, reset value of the output data register (DATA_W bits)
DIR_RESET, 0, reset value of the direction register; bit=1 means output
EDGE_TYPE, 0, edge capture mode: 0 rising, 1 falling, 2 any edge
SYNC_STAGES, 2, input synchroniser depth; legal 2..3

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
address  in  3  Avalon word address
chipselect  in  1  Avalon slave select
write_n  in  1  Avalon write strobe, active low
writedata  in  32  Avalon write data
readdata  out  32  registered Avalon read data
in_port  in  DATA_W  raw pad inputs (asynchronous to clk)
out_port  out  DATA_W  output data register
out_en  out  DATA_W  per-bit output enable (= direction register)
irq  out  1  level interrupt to CPU

Behaviour:
- Reset (async, active-high) values:
  - data_out = RESET_VALUE
  - dir = DIR_RESET
  - irq_mask = 0
  - edge_cap = 0
  - synchroniser flops = 0
  - edge history = 0
  - readdata = 0
  - irq = 0
- Reset asserted mid-transaction aborts it; no partial write survives.
- Write strobe: wr = chipselect & ~write_n. Only writedata[DATA_W-1:0] is used; upper bits are ignored.
- Register map (word address):
  - 0 DATA: write sets data_out. Read returns, per bit, data_out where dir=1 and in_sync where dir=0.
  - 1 DIR: read/write.
  - 2 IRQMASK: read/write.
  - 3 EDGECAP: read returns edge_cap. Write clears every bit written 1; bits written 0 are unchanged.
  - 4..7: reads return 0; writes are ignored (unless the optional feature is enabled).
- Write effect is visible on out_port/out_en the cycle after the write edge.
- Read path:
  - readdata <= zero-extended mux(address) on every clock, independent of chipselect.
  - Fixed read latency 1 cycle; no waitrequest.
  - Bits [31:DATA_W] are always 0.
- Synchroniser: in_port passes through a SYNC_STAGES flop chain to give in_sync. in_prev is in_sync delayed by one cycle.
- Edge detect, per bit:
  - rise = in_sync & ~in_prev
  - fall = ~in_sync & in_prev
  - EDGE_TYPE selects rise, fall, or rise|fall.
  - Detection is applied to all bits regardless of dir.
- Edge capture: edge_cap[i] is set on a detected edge and held until cleared by software.
- Simultaneous clear-write and new edge on the same bit in the same cycle: set wins, so the bit stays 1.
- Edge latency: a pad transition appears in edge_cap SYNC_STAGES+1 cycles after it is sampled.
- Interrupt:
  - irq <= |(edge_cap & irq_mask), registered, giving 1 cycle after edge_cap/mask change.
  - irq deasserts 1 cycle after the last enabled captured bit is cleared, or after its mask bit is cleared.
- Reset exit: first sync cycles must not fabricate edges. in_prev and the sync chain reset to 0, so a pad held high at reset exit produces one rising edge; this is required behaviour.

Optional Feature:
Macro HPI_PIO_OUTSET_CLR_EN.
- Defined:
  - address 4 OUTSET: data_out |= writedata.
  - address 5 OUTCLR: data_out &= ~writedata.
  - Both read back 0.
  - Atomic single-bit toggling of HPI control lines with no read-modify-write.
- Undefined: addresses 4/5 behave as 4..7 above; no set/clear logic is synthesised.

Test Plan:
- Reset state: reset high with DIR_RESET=0, RESET_VALUE=16'hA5A5, then release -> out_port=16'hA5A5, out_en=0, irq=0, reads of addr 0..3 return in_sync/0/0/0 with 1-cycle latency.
- Direction mux:
  - Write DIR=16'h00FF, DATA=16'h1234, drive in_port=16'hABCD.
  - After sync, read addr 0 -> 32'h0000AB34; out_en=16'h00FF.
- Rising edge capture (EDGE_TYPE=0):
  - Toggle in_port[3] 0->1 -> edge_cap=16'h0008 exactly 3 cycles after sampling (SYNC_STAGES=2).
  - 1->0 transition -> no new capture.
- Interrupt and W1C:
  - With edge_cap=16'h0009, write IRQMASK=16'h0008 -> irq=1 next cycle.
  - Write EDGECAP=16'h0008 -> edge_cap=16'h0001, irq=0 one cycle later.
- Collision: write EDGECAP=16'h0001 in the same cycle bit 0 detects a new edge -> edge_cap[0] remains 1.
- Optional feature, HPI_PIO_OUTSET_CLR_EN defined:
  - data_out=16'h00F0; write OUTSET=16'h0003, then OUTCLR=16'h0010 -> out_port=16'h00F3, then 16'h00E3.
  - Macro undefined -> data_out unchanged.
